// File: rtl/updown_count_tracker_pkg.sv
// Shared encodings for the up/down count tracker: FSM states and
// delta class codes produced by the classifier.
package updown_count_tracker_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        D_HOLD = 2'd0,
        D_INC  = 2'd1,
        D_DEC  = 2'd2,
        D_BAD  = 2'd3
    } delta_t;

endpackage

// File: rtl/updown_count_tracker_cnt_delta_classify.sv
// Combinational classifier: compares the previous and current observed
// count and reports whether the move was +1, -1, hold or an illegal jump.
// Arithmetic is modulo 2^CNT_W so 7->0 is +1 and 0->7 is -1 for CNT_W=3.
module cnt_delta_classify
    import updown_count_tracker_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic [CNT_W-1:0] i_prev,
    input  logic [CNT_W-1:0] i_cur,
    output logic [1:0]       o_class
);

    logic [CNT_W-1:0] w_delta;

    assign w_delta = i_cur - i_prev;

    // Map the modular difference onto one of the four delta classes.
    always_comb begin
        o_class = D_BAD;
        if (w_delta == '0)
            o_class = D_HOLD;
        else if (w_delta == CNT_W'(1))
            o_class = D_INC;
        else if (w_delta == '1)
            o_class = D_DEC;
    end

endmodule

// File: rtl/updown_count_tracker.sv
// Receive-side tracker for an up/down counter's state bus. Recovers the
// count direction, per-step pulses and a wide signed position, and counts
// illegal jumps with a saturating counter. All outputs are registered.
module updown_count_tracker
    import updown_count_tracker_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int POS_W     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic [CNT_W-1:0]     cnt_in,
    output logic                 dir,
    output logic                 dir_valid,
    output logic                 step,
    output logic                 err,
    output logic [POS_W-1:0]     pos,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    state_t                  r_state, w_state;
    logic                    r_primed, w_primed;
    logic [CNT_W-1:0]        r_prev, w_prev;
    logic signed [POS_W-1:0] r_pos, w_pos;
    logic [ERR_CNT_W-1:0]    r_err_cnt, w_err_cnt;
    logic                    r_dir, w_dir;
    logic                    r_dir_valid, w_dir_valid;
    logic                    r_step, w_step;
    logic                    r_err, w_err;
    logic [1:0]              w_class_raw;
    delta_t                  w_class;

    cnt_delta_classify #(
        .CNT_W (CNT_W)
    ) u_classify (
        .i_prev  (r_prev),
        .i_cur   (cnt_in),
        .o_class (w_class_raw)
    );

    assign w_class = delta_t'(w_class_raw);

    // Next-state and next-output logic; everything holds unless a sample is accepted.
    always_comb begin
        w_state   = r_state;
        w_primed  = r_primed;
        w_prev    = r_prev;
        w_pos     = r_pos;
        w_err_cnt = r_err_cnt;
        w_dir     = r_dir;
        w_step    = 1'b0;
        w_err     = 1'b0;
        if (sample_en) begin
            w_prev = cnt_in;
            if (!r_primed) begin
                // First sample after reset only establishes the reference value.
                w_primed = 1'b1;
            end else begin
                case (w_class)
                    D_INC: begin
                        w_state = ST_UP;
                        w_step  = 1'b1;
                        w_dir   = 1'b1;
                        w_pos   = r_pos + POS_ONE;
                    end
                    D_DEC: begin
                        w_state = ST_DOWN;
                        w_step  = 1'b1;
                        w_dir   = 1'b0;
                        w_pos   = r_pos - POS_ONE;
                    end
                    D_BAD: begin
                        w_state   = ST_FAULT;
                        w_err     = 1'b1;
                        w_err_cnt = sat_inc(r_err_cnt);
                    end
                    default: begin
                        w_state = r_state;
                    end
                endcase
            end
        end
        w_dir_valid = (w_state == ST_UP) || (w_state == ST_DOWN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_UNSYNC;
            r_primed    <= 1'b0;
            r_prev      <= '0;
            r_pos       <= '0;
            r_err_cnt   <= '0;
            r_dir       <= 1'b0;
            r_dir_valid <= 1'b0;
            r_step      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_primed    <= w_primed;
            r_prev      <= w_prev;
            r_pos       <= w_pos;
            r_err_cnt   <= w_err_cnt;
            r_dir       <= w_dir;
            r_dir_valid <= w_dir_valid;
            r_step      <= w_step;
            r_err       <= w_err;
        end
    end

    assign dir       = r_dir;
    assign dir_valid = r_dir_valid;
    assign step      = r_step;
    assign err       = r_err;
    assign pos       = r_pos;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_updown_count_tracker.sv
// Self-checking bench for updown_count_tracker: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
module tb_updown_count_tracker;

    logic        clk;
    logic        rst_n;
    logic        sample_en;
    logic [2:0]  cnt_in;
    logic        dir, dir_valid, step, err;
    logic [15:0] pos;
    logic [7:0]  err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: position as an integer, deltas via modular arithmetic.
    int m_prev, m_pos, m_errc;
    bit m_primed, m_tracking, m_dir, m_step, m_err;

    updown_count_tracker #(
        .CNT_W     (3),
        .POS_W     (16),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .cnt_in    (cnt_in),
        .dir       (dir),
        .dir_valid (dir_valid),
        .step      (step),
        .err       (err),
        .pos       (pos),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the model on the edge, settle 1 time unit after it.
    task automatic tick(input bit en, input int c, input bit rn);
        int d;
        sample_en = en;
        cnt_in    = 3'(c);
        rst_n     = rn;
        @(posedge clk);
        m_step = 0;
        m_err  = 0;
        if (!rn) begin
            m_prev = 0; m_pos = 0; m_errc = 0;
            m_primed = 0; m_tracking = 0; m_dir = 0;
        end else if (en) begin
            if (m_primed) begin
                d = (((c & 7) - m_prev) % 8 + 8) % 8;
                if (d == 1) begin
                    m_tracking = 1; m_dir = 1; m_pos = m_pos + 1; m_step = 1;
                end else if (d == 7) begin
                    m_tracking = 1; m_dir = 0; m_pos = m_pos - 1; m_step = 1;
                end else if (d != 0) begin
                    m_tracking = 0; m_err = 1;
                    if (m_errc < 255) m_errc = m_errc + 1;
                end
            end
            m_primed = 1;
            m_prev   = c & 7;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0);
        tick(1, 5, 0);
        n_cmp++; if ({dir, dir_valid, step, err} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {dir, dir_valid, step, err}); end
        n_cmp++; if (pos !== 16'h0000) begin n_fail++;
            $display("FAIL reset_pos: got %h expected 0000", pos); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_count_up();
        int steps = 0;
        int errs  = 0;
        tick(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, i % 8, 1);
            steps += step;
            errs  += err;
        end
        n_cmp++; if (steps !== 9) begin n_fail++;
            $display("FAIL up_steps: got %0d expected 9", steps); end
        n_cmp++; if (errs !== 0) begin n_fail++;
            $display("FAIL up_errs: got %0d expected 0", errs); end
        n_cmp++; if (pos !== 16'd9 || dir !== 1'b1) begin n_fail++;
            $display("FAIL up_pos_dir: got pos=%0d dir=%b expected pos=9 dir=1", pos, dir); end
    endtask

    task automatic test_count_down();
        int steps = 0;
        int seq[5] = '{3, 2, 1, 0, 7};
        tick(0, 0, 0);
        foreach (seq[i]) begin
            tick(1, seq[i], 1);
            steps += step;
        end
        n_cmp++; if (steps !== 4) begin n_fail++;
            $display("FAIL down_steps: got %0d expected 4", steps); end
        n_cmp++; if (pos !== 16'hFFFC || dir !== 1'b0 || dir_valid !== 1'b1) begin n_fail++;
            $display("FAIL down_pos_dir: got pos=%h dir=%b dv=%b expected FFFC 0 1", pos, dir, dir_valid); end
    endtask

    task automatic test_hold();
        logic [15:0] p0;
        tick(1, 0, 1);
        tick(1, 1, 1);
        tick(1, 2, 1);
        p0 = pos;
        n_cmp++; if (p0 !== 16'hFFFF) begin n_fail++;
            $display("FAIL hold_setup_pos: got %h expected FFFF", p0); end
        for (int i = 0; i < 3; i++) begin
            tick(1, 2, 1);
            n_cmp++; if (step !== 1'b0 || pos !== p0 || dir_valid !== 1'b1 || dir !== 1'b1) begin n_fail++;
                $display("FAIL hold: got step=%b pos=%h dv=%b dir=%b expected 0 %h 1 1", step, pos, dir_valid, dir, p0); end
        end
    endtask

    task automatic test_illegal();
        tick(0, 0, 0);
        tick(1, 0, 1);
        tick(1, 1, 1);
        n_cmp++; if (err !== 1'b0) begin n_fail++;
            $display("FAIL bad_pre_err: got %b expected 0", err); end
        tick(1, 4, 1);
        n_cmp++; if (err !== 1'b1 || err_cnt !== 8'd1 || dir_valid !== 1'b0 || pos !== 16'd1 || dir !== 1'b1) begin n_fail++;
            $display("FAIL bad_jump: got err=%b cnt=%0d dv=%b pos=%0d dir=%b expected 1 1 0 1 1", err, err_cnt, dir_valid, pos, dir); end
        tick(1, 5, 1);
        n_cmp++; if (err !== 1'b0 || step !== 1'b1 || dir_valid !== 1'b1 || pos !== 16'd2) begin n_fail++;
            $display("FAIL bad_recover: got err=%b step=%b dv=%b pos=%0d expected 0 1 1 2", err, step, dir_valid, pos); end
    endtask

    task automatic test_saturate();
        tick(0, 0, 0);
        for (int i = 0; i <= 300; i++) tick(1, (i % 2) * 4, 1);
        n_cmp++; if (err_cnt !== 8'd255 || err !== 1'b1) begin n_fail++;
            $display("FAIL sat_cnt: got cnt=%0d err=%b expected 255 1", err_cnt, err); end
        tick(1, 4, 0);
        n_cmp++; if ({dir, dir_valid, step, err} !== 4'b0000 || pos !== 16'd0 || err_cnt !== 8'd0) begin n_fail++;
            $display("FAIL sat_reset: got flags=%b pos=%0d cnt=%0d expected 0000 0 0", {dir, dir_valid, step, err}, pos, err_cnt); end
    endtask

    task automatic test_gating();
        int bad = 0;
        tick(1, 6, 1);
        tick(1, 7, 1);
        tick(1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tick(0, $urandom_range(0, 7), 1);
            if (step !== 1'b0 || err !== 1'b0 || pos !== 16'd2) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL gate_hold: got %0d bad cycles expected 0", bad); end
        tick(1, 1, 1);
        n_cmp++; if (step !== 1'b1 || pos !== 16'd3) begin n_fail++;
            $display("FAIL gate_resume: got step=%b pos=%0d expected 1 3", step, pos); end
        tick(1, 2, 0);
        n_cmp++; if (pos !== 16'd0 || step !== 1'b0) begin n_fail++;
            $display("FAIL rst_priority: got pos=%0d step=%b expected 0 0", pos, step); end
        tick(1, 5, 1);
        n_cmp++; if (err !== 1'b0 || step !== 1'b0 || pos !== 16'd0) begin n_fail++;
            $display("FAIL post_rst_first: got err=%b step=%b pos=%0d expected 0 0 0", err, step, pos); end
    endtask

    task automatic test_random();
        int bad = 0;
        int kind, c;
        bit en, rn;
        tick(0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            rn   = ($urandom_range(0, 99) != 0);
            kind = $urandom_range(0, 9);
            if (kind < 4)      c = (m_prev + 1) % 8;
            else if (kind < 7) c = (m_prev + 7) % 8;
            else if (kind < 8) c = m_prev;
            else               c = $urandom_range(0, 7);
            tick(en, c, rn);
            n_cmp++;
            if (dir !== m_dir || dir_valid !== m_tracking || step !== m_step || err !== m_err ||
                pos !== 16'(m_pos) || err_cnt !== 8'(m_errc)) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got dir=%b dv=%b step=%b err=%b pos=%h cnt=%0d expected %b %b %b %b %h %0d",
                             i, dir, dir_valid, step, err, pos, err_cnt,
                             m_dir, m_tracking, m_step, m_err, 16'(m_pos), m_errc);
                bad++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; cnt_in = 3'd0;
        test_reset();
        test_count_up();
        test_count_down();
        test_hold();
        test_illegal();
        test_saturate();
        test_gating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
